tt_um_hoene_protocol_forward: RTL and testbench
===============================================

TT_UM_HOENE_PROTOCOL_FORWARD -- requirements
Module: tt_um_hoene_protocol_forward

Interface
REQ-001 The block SHALL have the following ports, in this order:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_data  input  1  decoded bit value from the insync stage.
- in_clk  input  1  bit strobe; a rising edge marks in_data valid.
- in_sync  input  1  high while the upstream stream is in sync.
- swap_forward_bit  input  1  high inverts forwarded bits.
- pulsewidth  input  6  half-bit duration in clk cycles, from the Manchester decoder.
- out  output  1  re-encoded Manchester line to the next chip in the chain.
- busy  output  1  high while the encoder is transmitting or the FIFO is non-empty.
- overflow  output  1  sticky bit-dropped flag.
REQ-002 There SHALL be one clock; reset SHALL be asynchronous and active-low, named clk and rst_n.

Function
REQ-003 The block SHALL detect a rising edge of in_clk with one sampling register: edge = in_clk & ~in_clk_q.
REQ-004 On an edge with in_sync=1, the block SHALL push (in_data XOR swap_forward_bit) into a 4-entry bit FIFO in the same cycle.
REQ-005 An edge with in_sync=0 SHALL be ignored.
REQ-006 The encoder FSM SHALL have exactly three states: IDLE, FIRST_HALF, SECOND_HALF.
REQ-007 In IDLE with the FIFO non-empty, the FSM SHALL pop one bit, latch max(pulsewidth,1) as the half period, and enter FIRST_HALF on the next cycle.
REQ-008 The half-period counter SHALL count the latched value exactly, giving FIRST_HALF and SECOND_HALF each N cycles, where N is the latched value.
REQ-009 Encoding SHALL be: bit 1 = low then high; bit 0 = high then low. In IDLE, out SHALL be low.
REQ-010 At the end of SECOND_HALF, if the FIFO is non-empty the FSM SHALL pop the next bit and go directly to FIFO FIRST_HALF with no gap; otherwise it SHALL go to IDLE.
REQ-011 Pipeline latency SHALL be fixed: the first half of a bit starts 2 cycles after the cycle in which in_clk is first sampled high, when the FSM is IDLE.
REQ-012 Pushing into a full FIFO SHALL drop the new bit and keep the stored contents.
REQ-013 A push and a pop in the same cycle on a full FIFO SHALL both succeed; this is not an overflow.
REQ-014 A push and a pop in the same cycle on an empty FIFO SHALL NOT bypass the FIFO; the bit is popped on the following cycle.
REQ-015 A falling edge of in_sync SHALL flush the FIFO in the following cycle; a bit already in transmission SHALL complete both halves.
REQ-016 FIFO pointers SHALL be 2 bits and wrap modulo 4; a count register of 3 bits SHALL distinguish full from empty.
REQ-017 pulsewidth changes mid-bit SHALL NOT affect the bit in progress.

Reset
REQ-018 While rst_n=0, the block SHALL force: out=0, busy=0, overflow=0, FSM=IDLE, FIFO empty, in_clk_q=0, counter=0.
REQ-019 Reset asserted mid-bit SHALL abort the bit immediately, driving out low asynchronously.
REQ-020 On reset release, the first in_clk high sample SHALL be treated as an edge.

Configuration
REQ-021 With macro TT_UM_HOENE_FORWARD_OVERFLOW_EN defined, overflow SHALL set on any dropped bit and clear only on reset or on an in_sync falling edge.
REQ-022 Without TT_UM_HOENE_FORWARD_OVERFLOW_EN, overflow SHALL be tied to 0, with drop behaviour unchanged.

Structure
REQ-023 The FIFO depth constant (4), pointer width, and FSM state encodings (IDLE=0, FIRST_HALF=1, SECOND_HALF=2) SHALL live in the shared protocol include header.
REQ-024 The FIFO SHALL be a separate sub-module, tt_um_hoene_forward_fifo, with ports: push, pop, din, dout, empty, full, flush.

Verification
REQ-025 The bench SHALL cover at least these directed scenarios:
- Single bit 1, pulsewidth=4, in_sync=1: out low 4 cycles then high 4 cycles, starting 2 cycles after in_clk high; busy falls after cycle 8.
- Bits 1,0,1 back-to-back, pulsewidth=3: continuous 18-cycle waveform L L L H H H, H H H L L L, L L L H H H with no idle gap.
- swap_forward_bit=1, in_data=0: waveform equals that of bit 1.
- Six bits pushed in consecutive strobes while pulsewidth=20: bits 1-5 transmitted (one in flight plus four queued), bit 6 dropped; overflow=1 only with the macro defined.
- pulsewidth=0: half period is 1 cycle.
- in_sync falls with 3 bits queued mid-bit: the current bit completes, the queue is discarded, out returns low, and overflow clears.
- rst_n pulsed low mid-FIRST_HALF: out=0 immediately and all outputs at their reset values.

Source files
------------

// File: rtl/tt_um_hoene_protocol_forward_pkg.sv
// Shared protocol constants for the Manchester forwarding stage.
// Holds the bit-FIFO geometry, the half-period width and the encoder
// state encodings (IDLE=0, FIRST_HALF=1, SECOND_HALF=2). It also provides
// a helper that clamps a zero pulsewidth to a one-cycle half period.
package tt_um_hoene_protocol_forward_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;   // wraps modulo FIFO_DEPTH
    localparam int CNT_W      = 3;   // 0..FIFO_DEPTH, separates full from empty
    localparam int PW_W       = 6;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FIRST_HALF  = 2'd1,
        SECOND_HALF = 2'd2
    } enc_state_t;

    // A zero half period would never advance the encoder, so treat it as 1.
    function automatic logic [PW_W-1:0] clamp_half(input logic [PW_W-1:0] pw);
        return (pw == '0) ? PW_W'(1) : pw;
    endfunction

endpackage

// File: rtl/tt_um_hoene_forward_fifo.sv
// 4-entry single-bit FIFO that buffers decoded bits ahead of the encoder.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data bit
//   pop, dout  : read request and head-of-queue bit (dout is valid when !empty)
//   empty/full : occupancy flags from the 3-bit count
//   flush      : synchronous clear of all entries; it takes priority over push/pop
// Handshake: a push is accepted when the FIFO is not full, or when a pop is
// accepted in the same cycle. A pop is accepted when the FIFO is not empty.
// A rejected push is simply dropped and the stored contents are unchanged.
// No data bypasses storage: a bit pushed into an empty FIFO is poppable next cycle.
module tt_um_hoene_forward_fifo
    import tt_um_hoene_protocol_forward_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic empty,
    output logic full,
    input  logic flush
);

    logic [FIFO_DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tt_um_hoene_protocol_forward.sv
// Re-encodes decoded bits as a Manchester line for the next chip in the chain.
// Rising edges of in_clk (while in_sync is high) push in_data ^ swap_forward_bit
// into a 4-entry FIFO; a three-state encoder pops bits and drives each one
// as two half periods of max(pulsewidth,1) cycles (bit 1: low then high,
// bit 0: high then low). A falling edge of in_sync discards queued bits, but
// the bit currently on the line completes.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_data, in_clk   : decoded bit and its strobe
//   in_sync           : upstream in-sync indicator
//   swap_forward_bit  : inverts forwarded bits
//   pulsewidth        : half-bit duration in clk cycles
//   out               : Manchester output (low when idle or in reset)
//   busy              : encoder active or FIFO non-empty
//   overflow          : sticky drop flag
// Optional feature macro: TT_UM_HOENE_FORWARD_OVERFLOW_EN enables the sticky
// overflow flag. Without it, overflow is tied low and drops are silent.
module tt_um_hoene_protocol_forward
    import tt_um_hoene_protocol_forward_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_data,
    input  logic            in_clk,
    input  logic            in_sync,
    input  logic            swap_forward_bit,
    input  logic [PW_W-1:0] pulsewidth,
    output logic            out,
    output logic            busy,
    output logic            overflow
);

    logic            r_in_clk_q;
    logic            r_sync_q;
    enc_state_t      r_state;
    enc_state_t      w_next_state;
    logic            r_bit;
    logic [PW_W-1:0] r_half;
    logic [PW_W-1:0] r_cnt;

    logic            w_edge;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_din;
    logic            w_fifo_dout;
    logic            w_empty;
    logic            w_full;
    logic            w_drop;
    logic            w_half_done;
    logic            w_out;

    // r_in_clk_q resets to 0, so an in_clk already high at reset release is an edge.
    assign w_edge  = in_clk & ~r_in_clk_q;
    assign w_push  = w_edge & in_sync;
    assign w_flush = r_sync_q & ~in_sync;
    assign w_din   = in_data ^ swap_forward_bit;
    assign w_drop  = w_push & w_full & ~w_pop;

    tt_um_hoene_forward_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_fifo_dout),
        .empty (w_empty),
        .full  (w_full),
        .flush (w_flush)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_clk_q <= 1'b0;
            r_sync_q   <= 1'b0;
        end else begin
            r_in_clk_q <= in_clk;
            r_sync_q   <= in_sync;
        end
    end

    assign w_half_done = (r_cnt == '0);

    // Next-state logic. A flush cycle never pops, so the bit being discarded
    // cannot slip into the encoder.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !w_flush) begin
                    w_pop        = 1'b1;
                    w_next_state = FIRST_HALF;
                end
            end
            FIRST_HALF: begin
                if (w_half_done) begin
                    w_next_state = SECOND_HALF;
                end
            end
            SECOND_HALF: begin
                if (w_half_done) begin
                    if (!w_empty && !w_flush) begin
                        w_pop        = 1'b1;
                        w_next_state = FIRST_HALF;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // The half period is latched at pop time, so later pulsewidth changes only
    // affect later bits. The counter runs N-1..0 for each half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_bit   <= 1'b0;
            r_half  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                r_bit  <= w_fifo_dout;
                r_half <= clamp_half(pulsewidth);
                r_cnt  <= clamp_half(pulsewidth) - PW_W'(1);
            end else if (w_next_state == IDLE) begin
                r_cnt <= '0;
            end else if (w_half_done) begin
                r_cnt <= r_half - PW_W'(1);
            end else begin
                r_cnt <= r_cnt - PW_W'(1);
            end
        end
    end

    // Decoded from the state register, so reset drops the line immediately.
    always_comb begin
        w_out = 1'b0;
        case (r_state)
            FIRST_HALF:  w_out = ~r_bit;
            SECOND_HALF: w_out = r_bit;
            default:     w_out = 1'b0;
        endcase
    end

    assign out  = w_out;
    assign busy = (r_state != IDLE) | ~w_empty;

`ifdef TT_UM_HOENE_FORWARD_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_flush) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop;
    assign overflow      = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_hoene_protocol_forward.sv
module tb_tt_um_hoene_protocol_forward;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_data;
    logic       in_clk;
    logic       in_sync;
    logic       swap_forward_bit;
    logic [5:0] pulsewidth;
    logic       out;
    logic       busy;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    // Expected {busy, out} per clock, compared at each falling edge.
    logic [1:0] exp_q[$];

`ifdef TT_UM_HOENE_FORWARD_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    tt_um_hoene_protocol_forward dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_data          (in_data),
        .in_clk           (in_clk),
        .in_sync          (in_sync),
        .swap_forward_bit (swap_forward_bit),
        .pulsewidth       (pulsewidth),
        .out              (out),
        .busy             (busy),
        .overflow         (overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [1:0] exp_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            total++;
            if ({busy, out} !== exp_v) begin
                bad++;
                $display("FAIL wave @%0t: got busy/out=%b required %b", $time, {busy, out}, exp_v);
            end
        end
    end

    // ---------------- driver / expectation tasks ----------------
    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(2'b00);
    endtask

    // Strobe issued at posedge+1: one idle cycle, then one cycle with the bit queued.
    task automatic push_latency();
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    task automatic push_bit(input logic b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, ~b});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, b});
    endtask

    // Called at posedge+1; returns at posedge+1 two cycles later.
    task automatic strobe(input logic d);
        in_data = d;
        in_clk  = 1'b1;
        @(posedge clk); #1;
        in_clk  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s drain: got %0d entries left required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n            = 1'b0;
        in_data          = 1'b0;
        in_clk           = 1'b0;
        in_sync          = 1'b1;
        swap_forward_bit = 1'b0;
        pulsewidth       = 6'd4;
        #1;
        total += 3;
        if (out !== 1'b0)      begin bad++; $display("FAIL reset out: got %b required 0", out); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL reset busy: got %b required 0", busy); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset overflow: got %b required 0", overflow); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total += 2;
        if (out !== 1'b0)  begin bad++; $display("FAIL post_reset out: got %b required 0", out); end
        if (busy !== 1'b0) begin bad++; $display("FAIL post_reset busy: got %b required 0", busy); end
    endtask

    task automatic test_single_bit();
        pulsewidth = 6'd4;
        push_latency();
        push_bit(1'b1, 4);
        push_idle(3);
        strobe(1'b1);
        wait_drain("single_bit", 60);
    endtask

    task automatic test_back_to_back();
        pulsewidth = 6'd3;
        push_latency();
        push_bit(1'b1, 3);
        push_bit(1'b0, 3);
        push_bit(1'b1, 3);
        push_idle(3);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        wait_drain("back_to_back", 60);
    endtask

    task automatic test_swap();
        pulsewidth       = 6'd3;
        swap_forward_bit = 1'b1;
        push_latency();
        push_bit(1'b1, 3);
        push_idle(3);
        strobe(1'b0);
        wait_drain("swap", 40);
        swap_forward_bit = 1'b0;
    endtask

    task automatic test_overflow();
        logic [5:0] bits;
        bits = 6'b101101;   // sent LSB first: 1,0,1,1,0,1
        pulsewidth = 6'd20;
        push_latency();
        for (int i = 0; i < 5; i++) push_bit(bits[i], 20);
        push_idle(3);
        for (int i = 0; i < 6; i++) strobe(bits[i]);
        total++;
        if (overflow !== OVF_EXP) begin
            bad++;
            $display("FAIL overflow_set: got %b required %b", overflow, OVF_EXP);
        end
        wait_drain("overflow", 300);
        total++;
        if (overflow !== OVF_EXP) begin
            bad++;
            $display("FAIL overflow_sticky: got %b required %b", overflow, OVF_EXP);
        end
    endtask

    task automatic test_sync_fall();
        pulsewidth = 6'd4;
        push_latency();
        push_bit(1'b1, 4);   // only the in-flight bit survives the flush
        push_idle(6);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b0);
        strobe(1'b1);        // now mid SECOND_HALF with 3 bits queued
        in_sync = 1'b0;
        wait_drain("sync_fall", 40);
        total += 2;
        if (overflow !== 1'b0) begin bad++; $display("FAIL sync_fall overflow: got %b required 0", overflow); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL sync_fall busy: got %b required 0", busy); end
        // Strobes while out of sync are ignored.
        push_idle(6);
        strobe(1'b1);
        wait_drain("no_sync", 20);
        in_sync = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_pw_zero();
        pulsewidth = 6'd0;
        push_latency();
        push_bit(1'b1, 1);
        push_idle(3);
        strobe(1'b1);
        pulsewidth = 6'd5;   // bit already latched with a 1-cycle half period
        wait_drain("pw_zero", 20);
    endtask

    task automatic test_reset_mid_bit();
        pulsewidth = 6'd4;
        strobe(1'b0);        // returns in the first cycle of FIRST_HALF
        total++;
        if (out !== 1'b1) begin bad++; $display("FAIL mid_bit out: got %b required 1", out); end
        in_data = 1'b1;
        in_clk  = 1'b1;
        rst_n   = 1'b0;
        #1;
        total += 3;
        if (out !== 1'b0)      begin bad++; $display("FAIL async_reset out: got %b required 0", out); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL async_reset busy: got %b required 0", busy); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL async_reset overflow: got %b required 0", overflow); end
        repeat (2) @(posedge clk);
        #1;
        // in_clk held high across reset release must count as an edge.
        push_latency();
        push_bit(1'b1, 4);
        push_idle(3);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_clk = 1'b0;
        wait_drain("reset_release_edge", 40);
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_back_to_back();
        test_swap();
        test_overflow();
        test_sync_fall();
        test_pw_zero();
        test_reset_mid_bit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
